// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci iteration counter.
package fib_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ctr_state_t;

    localparam logic MODE_STEP1 = 1'b0;
    localparam logic MODE_STEP2 = 1'b1;

    // A run terminates once the remaining count drops below this value.
    localparam int FIB_TERM_LIMIT = 2;

endpackage

// File: rtl/fib_iter_ctr_if.sv
// Handshake bundle between the Fibonacci controller/datapath and the counter.
// Optional iteration counter port appears when FIB_CTR_ITER_EN is defined.
interface fib_iter_ctr_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] n;
    logic             mode;
    logic             step_req;
    logic             step_ack;
    logic [WIDTH-1:0] count;
    logic             lt;
    logic             busy;
    logic             done;
`ifdef FIB_CTR_ITER_EN
    logic [WIDTH-1:0] iter;

    modport master (
        output start, n, mode, step_req,
        input  step_ack, count, lt, busy, done, iter
    );
    modport slave (
        input  start, n, mode, step_req,
        output step_ack, count, lt, busy, done, iter
    );
`else
    modport master (
        output start, n, mode, step_req,
        input  step_ack, count, lt, busy, done
    );
    modport slave (
        input  start, n, mode, step_req,
        output step_ack, count, lt, busy, done
    );
`endif
endinterface

// File: rtl/fib_ctr_dec.sv
// Combinational step/compare unit: floored count-step and termination flags.
module fib_ctr_dec
    import fib_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] count,
    input  logic             mode_r,
    output logic [WIDTH-1:0] nxt,
    output logic             last,
    output logic             lt
);

    logic [WIDTH:0] step;
    logic [WIDTH:0] diff;

    // Subtract one bit wider so the top bit is the borrow; a borrow floors to 0.
    assign step = (mode_r == MODE_STEP2) ? (WIDTH+1)'(2) : (WIDTH+1)'(1);
    assign diff = {1'b0, count} - step;
    assign nxt  = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
    assign last = nxt < WIDTH'(FIB_TERM_LIMIT);
    assign lt   = count < WIDTH'(FIB_TERM_LIMIT);

endmodule

// File: rtl/fib_iter_ctr.sv
// Loadable down-counter sequencing a Fibonacci iteration loop.
// start/step_req handshake, registered step_ack and done pulses.
// Define FIB_CTR_ITER_EN to add a saturating per-run step counter (iter).
module fib_iter_ctr #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    fib_iter_ctr_if.slave bus
);
    import fib_pkg::*;

    ctr_state_t       state, state_nxt;
    logic [WIDTH-1:0] count_r, count_nxt;
    logic             mode_r, mode_nxt;
    logic             ack_r, ack_nxt;
    logic             done_r, done_nxt;
    logic [WIDTH-1:0] dec_nxt;
    logic             dec_last;
    logic             dec_lt;

    fib_ctr_dec #(.WIDTH(WIDTH)) u_dec (
        .count  (count_r),
        .mode_r (mode_r),
        .nxt    (dec_nxt),
        .last   (dec_last),
        .lt     (dec_lt)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state, next count/mode and handshake pulses.
    always_comb begin
        state_nxt = state;
        count_nxt = count_r;
        mode_nxt  = mode_r;
        ack_nxt   = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    count_nxt = bus.n;
                    mode_nxt  = bus.mode;
                    // Too short to iterate: finish without entering RUN.
                    if (bus.n < WIDTH'(FIB_TERM_LIMIT)) done_nxt  = 1'b1;
                    else                                 state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.step_req) begin
                    count_nxt = dec_nxt;
                    ack_nxt   = 1'b1;
                    if (dec_last) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
            mode_r  <= MODE_STEP1;
            ack_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            count_r <= count_nxt;
            mode_r  <= mode_nxt;
            ack_r   <= ack_nxt;
            done_r  <= done_nxt;
        end
    end

    assign bus.count    = count_r;
    assign bus.lt       = dec_lt;
    assign bus.busy     = (state == RUN);
    assign bus.step_ack = ack_r;
    assign bus.done     = done_r;

`ifdef FIB_CTR_ITER_EN
    logic [WIDTH-1:0] iter_r;

    // Steps taken in the current run; cleared on start, held after done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              iter_r <= '0;
        else if (state == IDLE && bus.start)  iter_r <= '0;
        else if (ack_nxt && (iter_r != '1))   iter_r <= iter_r + 1'b1;
    end

    assign bus.iter = iter_r;
`endif

endmodule

// File: tb/tb_fib_iter_ctr.sv
// Directed bench for fib_iter_ctr: vector table on an 8-bit instance,
// hand sequences for async reset, a 4-bit long run and the iter option.
module tb_fib_iter_ctr;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fib_iter_ctr_if #(.WIDTH(8)) bus8 ();
    fib_iter_ctr_if #(.WIDTH(4)) bus4 ();

    fib_iter_ctr #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    fib_iter_ctr #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    typedef struct {
        logic       start;
        logic [7:0] n;
        logic       mode;
        logic       req;
        logic [7:0] count;
        logic       ack;
        logic       busy;
        logic       done;
        logic       lt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic s, input logic [7:0] nn, input logic m, input logic r,
                               input logic [7:0] c, input logic a, input logic b, input logic d,
                               input logic l);
        vec_t t;
        t.start = s; t.n = nn; t.mode = m; t.req = r;
        t.count = c; t.ack = a; t.busy = b; t.done = d; t.lt = l;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acks;
        int dones;
        int exp4;
        bus8.start = 0; bus8.n = 0; bus8.mode = 0; bus8.step_req = 0;
        bus4.start = 0; bus4.n = 0; bus4.mode = 0; bus4.step_req = 0;

        // Reset state.
        #2;
        chk("reset_count", 32'(bus8.count), 32'd0);
        chk("reset_flags", {bus8.step_ack, bus8.busy, bus8.done, bus8.lt}, 32'b0001);
        tick();
        rst = 1'b0;
        tick();

        // {start,n,mode,req} -> {count,ack,busy,done,lt} after the next edge.
        vecs.push_back(v(1, 5,   0, 1, 5,   0, 1, 0, 0));
        vecs.push_back(v(0, 0,   0, 1, 4,   1, 1, 0, 0));
        vecs.push_back(v(0, 0,   0, 1, 3,   1, 1, 0, 0));
        vecs.push_back(v(0, 0,   0, 1, 2,   1, 1, 0, 0));
        vecs.push_back(v(0, 0,   0, 1, 1,   1, 0, 1, 1));
        vecs.push_back(v(0, 0,   0, 1, 1,   0, 0, 0, 1));
        vecs.push_back(v(1, 6,   1, 1, 6,   0, 1, 0, 0));
        vecs.push_back(v(0, 0,   0, 1, 4,   1, 1, 0, 0));
        vecs.push_back(v(0, 0,   0, 1, 2,   1, 1, 0, 0));
        vecs.push_back(v(0, 0,   0, 1, 0,   1, 0, 1, 1));
        vecs.push_back(v(0, 0,   0, 1, 0,   0, 0, 0, 1));
        vecs.push_back(v(1, 1,   0, 0, 1,   0, 0, 1, 1));
        vecs.push_back(v(0, 0,   0, 0, 1,   0, 0, 0, 1));
        vecs.push_back(v(1, 3,   0, 0, 3,   0, 1, 0, 0));
        vecs.push_back(v(0, 0,   0, 0, 3,   0, 1, 0, 0));
        vecs.push_back(v(1, 9,   0, 0, 3,   0, 1, 0, 0));
        vecs.push_back(v(0, 0,   0, 1, 2,   1, 1, 0, 0));
        vecs.push_back(v(0, 0,   0, 1, 1,   1, 0, 1, 1));
        vecs.push_back(v(1, 2,   1, 0, 2,   0, 1, 0, 0));
        vecs.push_back(v(0, 0,   0, 1, 0,   1, 0, 1, 1));
        vecs.push_back(v(1, 0,   0, 1, 0,   0, 0, 1, 1));
        vecs.push_back(v(0, 0,   0, 0, 0,   0, 0, 0, 1));
        vecs.push_back(v(1, 255, 1, 0, 255, 0, 1, 0, 0));
        vecs.push_back(v(0, 0,   0, 1, 253, 1, 1, 0, 0));

        foreach (vecs[i]) begin
            bus8.start = vecs[i].start; bus8.n = vecs[i].n;
            bus8.mode = vecs[i].mode;   bus8.step_req = vecs[i].req;
            tick();
            chk($sformatf("vec%0d", i),
                {bus8.count, bus8.step_ack, bus8.busy, bus8.done, bus8.lt},
                {vecs[i].count, vecs[i].ack, vecs[i].busy, vecs[i].done, vecs[i].lt});
        end

        // Async reset mid-run, observed before the next clock edge.
        bus8.step_req = 0;
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_count", 32'(bus8.count), 32'd0);
        chk("async_rst_flags", {bus8.step_ack, bus8.busy, bus8.done, bus8.lt}, 32'b0001);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_no_done", {bus8.busy, bus8.done}, 32'b00);

        // 4-bit long run, mode 2, step_req toggling; start held during RUN.
        bus4.start = 1; bus4.n = 4'd15; bus4.mode = 1; bus4.step_req = 0;
        tick();
        chk("w4_load", {bus4.count, bus4.busy}, {4'd15, 1'b1});
        bus4.n = 4'd3; bus4.mode = 0;
        acks = 0; dones = 0; exp4 = 15;
        for (int i = 0; i < 14; i++) begin
            bus4.start    = (i < 12);
            bus4.step_req = (i % 2 == 0);
            tick();
            if (i % 2 == 0) exp4 -= 2;
            if (bus4.step_ack) acks++;
            if (bus4.done) dones++;
            chk($sformatf("w4_count%0d", i), 32'(bus4.count), 32'(exp4));
        end
        chk("w4_acks", 32'(acks), 32'd7);
        chk("w4_dones", 32'(dones), 32'd1);
        chk("w4_end", {bus4.count, bus4.busy, bus4.lt}, {4'd1, 1'b0, 1'b1});
        bus4.step_req = 1;
        tick();
        chk("w4_idle_ignore", {bus4.count, bus4.step_ack}, {4'd1, 1'b0});
        bus4.step_req = 0;

`ifdef FIB_CTR_ITER_EN
        bus8.start = 1; bus8.n = 6; bus8.mode = 1; bus8.step_req = 1;
        tick();
        chk("iter_clear", 32'(bus8.iter), 32'd0);
        bus8.start = 0;
        tick(); tick(); tick();
        chk("iter_done", {bus8.done, bus8.count}, {1'b1, 8'd0});
        chk("iter_three", 32'(bus8.iter), 32'd3);
        bus8.step_req = 0;
        tick();
        chk("iter_hold", 32'(bus8.iter), 32'd3);
        bus8.start = 1; bus8.n = 10; bus8.mode = 0;
        tick();
        chk("iter_restart", 32'(bus8.iter), 32'd0);
        bus8.start = 0; bus8.step_req = 1;
        tick();
        chk("iter_one", 32'(bus8.iter), 32'd1);
        bus8.step_req = 0;
        #3;
        rst = 1'b1;
        #1;
        chk("iter_rst", {bus8.iter, bus8.done, bus8.busy}, {8'd0, 1'b0, 1'b0});
        tick();
        rst = 1'b0;
        tick();
        chk("iter_rst_no_done", {bus8.done, bus8.iter}, {1'b0, 8'd0});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
